// File: rtl/pixel_write_sink.sv
// Pixel write sink: buffers drawing-engine pixel writes in a small FIFO and streams them,
// or a full-screen clear, to a framebuffer port through a valid/ready output register.
module pixel_write_sink #(
    parameter int unsigned XSCREEN     = 640,
    parameter int unsigned YSCREEN     = 480,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [8:0]  CLEAR_COLOR = 9'b111_111_111
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [9:0]  VGA_x,
    input  logic [8:0]  VGA_y,
    input  logic [8:0]  VGA_color,
    input  logic        VGA_write,
    input  logic        clear_req,
    output logic [18:0] mem_addr,
    output logic [8:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic        overflow,
    output logic        oob
);

    localparam int unsigned AW    = 19;
    localparam int unsigned CW    = 9;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(XSCREEN * YSCREEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] color;
    } pix_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    pix_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             clear_pend_q, clear_pend_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [CW-1:0]    mem_data_q, mem_data_d;
    logic             mem_we_q, mem_we_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic             oob_q, oob_d;

    logic             in_range_c;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             out_free_c;
    logic             enq_c;
    logic             deq_c;
    pix_t             in_pix_c;
    pix_t             head_c;

    // Incoming pixel decode; address is row*width + column at framebuffer width
    always_comb begin
        in_range_c     = (11'(VGA_x) < 11'(XSCREEN)) && (10'(VGA_y) < 10'(YSCREEN));
        in_pix_c.addr  = (AW'(VGA_y) * AW'(XSCREEN)) + AW'(VGA_x);
        in_pix_c.color = VGA_color;
        head_c         = fifo_q[rd_ptr_q];
        fifo_full_c    = (count_q == FULL_CNT);
        fifo_empty_c   = (count_q == '0);
        out_free_c     = !mem_we_q || mem_ready;
    end

    // Next-state, output-register and FIFO control
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_pend_d = clear_pend_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = mem_we_q;
        deq_c        = 1'b0;

        if (mem_we_q && mem_ready) begin
            mem_we_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if ((clear_req || clear_pend_q) && out_free_c) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = '0;
                    mem_data_d   = CLEAR_COLOR;
                    clr_cnt_d    = AW'(1);
                end else begin
                    if (clear_req) begin
                        clear_pend_d = 1'b1;
                    end
                    if (out_free_c && !fifo_empty_c) begin
                        deq_c      = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = head_c.addr;
                        mem_data_d = head_c.color;
                    end
                end
            end
            CLEAR: begin
                // clr_cnt_q holds the next address to issue once the current one transfers
                if (mem_we_q && mem_ready) begin
                    if (mem_addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = clr_cnt_q;
                        mem_data_d = CLEAR_COLOR;
                        clr_cnt_d  = clr_cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enq_c = VGA_write && in_range_c && (!fifo_full_c || deq_c);

        case ({enq_c, deq_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q || (VGA_write && in_range_c && fifo_full_c && !deq_c);
        oob_d      = oob_q || (VGA_write && !in_range_c);
        busy_d     = (state_d == CLEAR) || (count_d != '0) || mem_we_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            clr_cnt_q    <= '0;
            clear_pend_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_pend_q <= clear_pend_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            oob_q        <= oob_d;
            if (enq_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; pointers and count define validity
    always_ff @(posedge Clock) begin
        if (enq_c) begin
            fifo_q[wr_ptr_q] <= in_pix_c;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign oob      = oob_q;

endmodule

// File: doc/pixel_write_sink.md
PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XSCREEN, 640, screen width in pixels.
- YSCREEN, 480, screen height in pixels.
- FIFO_DEPTH, 8, pixel-write buffer entries (power of two).
- CLEAR_COLOR, 9'b111_111_111, fill colour for screen clear.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clock, in, 1, sole clock; all logic on its rising edge.
- Reset, in, 1, synchronous, active-high reset.
- VGA_x, in, 10, pixel column from the drawing engine.
- VGA_y, in, 9, pixel row from the drawing engine.
- VGA_color, in, 9, pixel colour RRRGGGBBB.
- VGA_write, in, 1, pixel-write strobe; one pixel per cycle when high; no backpressure.
- clear_req, in, 1, single-cycle request to fill the whole screen with CLEAR_COLOR.
- mem_addr, out, 19, framebuffer word address.
- mem_data, out, 9, framebuffer write data.
- mem_we, out, 1, memory write valid.
- mem_ready, in, 1, memory accepts the write this cycle.
- busy, out, 1, high while a clear is in progress, the FIFO is non-empty, or mem_we is high.
- overflow, out, 1, sticky: an in-range pixel was dropped because the FIFO was full.
- oob, out, 1, sticky: a pixel with VGA_x>=XSCREEN or VGA_y>=YSCREEN was discarded.

Function
REQ-003 On each edge with VGA_write=1 and the pixel in range, the block SHALL enqueue {addr, color}, with addr = VGA_y*XSCREEN + VGA_x computed at 19-bit width (y*640 = (y<<9)+(y<<7)).
REQ-004 Out-of-range pixels SHALL NOT be enqueued; they SHALL set oob.
REQ-005 When the FIFO holds FIFO_DEPTH entries and no dequeue occurs that edge, an in-range write SHALL be dropped and SHALL set overflow.
REQ-006 A write arriving while the FIFO is full SHALL be accepted if a dequeue occurs on the same edge; the count SHALL be unchanged.
REQ-007 The output register {mem_addr, mem_data, mem_we} SHALL follow a valid/ready handshake. A transfer occurs on an edge where mem_we=1 and mem_ready=1. While mem_we=1 and mem_ready=0, mem_addr and mem_data SHALL hold stable.
REQ-008 The FSM SHALL have two states, IDLE and CLEAR.
REQ-009 In IDLE, if the output register is empty or transferring, and the FIFO is non-empty, the FIFO head SHALL be loaded into the output register and mem_we SHALL be 1 after that edge. Otherwise mem_we SHALL go 0 after a transfer.
REQ-010 Latency: a pixel enqueued at edge N into an empty FIFO with an idle output SHALL appear on mem_we/mem_addr after edge N+1. With mem_ready held at 1, sustained throughput SHALL be 1 pixel per cycle.
REQ-011 IDLE->CLEAR SHALL occur on an edge with clear_req=1 while the output register is empty or transferring. A clear_req that arrives while the output register is stalled SHALL be latched as pending and serviced when that condition is met.
REQ-012 In CLEAR, the block SHALL issue addresses 0 through XSCREEN*YSCREEN-1 (0..307199) in order, with mem_data=CLEAR_COLOR and the same handshake as REQ-007. The FIFO SHALL NOT be dequeued during CLEAR.
REQ-013 CLEAR->IDLE SHALL occur on the transfer of address 307199. The buffered FIFO pixels SHALL then drain in arrival order.
REQ-014 clear_req asserted during CLEAR SHALL be ignored and SHALL NOT restart the address counter.
REQ-015 Pixel input SHALL continue to enqueue during CLEAR, subject to REQ-005.
REQ-016 overflow and oob SHALL clear only on Reset.

Reset
REQ-017 While Reset=1 at an edge:
- state SHALL become IDLE.
- The FIFO SHALL empty (pointers and count 0).
- The clear counter SHALL become 0 and the pending clear SHALL be cancelled.
- mem_we, busy, overflow and oob SHALL become 0.
- mem_addr and mem_data SHALL become 0.
REQ-018 Reset asserted mid-CLEAR or mid-stall SHALL abort the operation. No mem_we SHALL occur in the cycle after the reset edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single write: mem_ready=1; write x=5, y=2, color=9'h1C7 at edge N -> mem_we=1, mem_addr=1285, mem_data=9'h1C7 after edge N+1, for one cycle.
- Stall: mem_ready=0, 3 writes issued -> mem_addr holds the first address and busy=1. Then mem_ready=1 -> 3 transfers on consecutive edges, in order, then mem_we=0.
- Overflow: mem_ready=0, 10 consecutive writes with FIFO_DEPTH=8 -> 1 pixel in the output register, 8 in the FIFO, the 10th dropped, overflow=1. Releasing mem_ready -> exactly 9 transfers.
- Bounds: write x=640, y=0 and x=0, y=480 -> no mem_we, oob=1. Then x=639, y=479 -> mem_addr=307199.
- Clear: pulse clear_req with mem_ready=1 -> 307200 transfers, addresses 0..307199, data 9'h1FF. A write of x=1, y=0 issued mid-clear appears at address 1 after address 307199. A second clear_req mid-clear has no effect.
- Reset mid-clear: assert Reset at clear address 1000 -> mem_we=0, busy=0 after the edge. A new clear_req restarts from address 0.
